pipe_mdu: RTL and testbench

Multi-cycle multiply (optionally divide) unit with architectural HI/LO registers, sitting in the EX stage directly downstream of the ID/EX pipeline register of the pipelined MIPS CPU. It consumes the E-stage operands and the mult/mfhi/mflo controls, runs an iterative shift-add sequence, and drives a stall back to the front of the pipeline while a later instruction needs the unit before it is done. mfhi/mflo results leave through a read port into the EX result mux.

---
 rtl/pipe_mdu_pkg.sv | 18 +
 rtl/pipe_mdu_abs.sv | 12 +
 rtl/pipe_mdu.sv | 135 +++++++++++++
 tb/tb_pipe_mdu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mdu_pkg.sv
// pipe_mdu_pkg: shared types and constants for the EX-stage multiply/divide unit (MDU_DIV_EN adds the DIV state)
package pipe_mdu_pkg;

    localparam int ITER = 32;
    localparam int CW = 5;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif

    function automatic logic last_iter(input logic [CW-1:0] c);
        return c == CW'(ITER - 1);
    endfunction

endpackage

// File: rtl/pipe_mdu_abs.sv
// pipe_mdu_abs: conditional two's-complement negate, used for operand magnitudes and result sign fix-up
module pipe_mdu_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -a : a;

endmodule

// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative multiply (and, with MDU_DIV_EN, restoring divide) unit with HI/LO and pipeline stall
module pipe_mdu
    import pipe_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic            emult,
    input  logic            esign,
    input  logic            ediv,
    input  logic            emfhi,
    input  logic            emflo,
    output logic [XLEN-1:0] mdu_out,
    output logic            mdu_busy,
    output logic            mdu_stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_t            state;
    state_t            run_st;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] res;
    logic [XLEN:0]     madd;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic              rsign;
    logic              busy;
    logic              start;

    pipe_mdu_abs #(.W(XLEN)) u_abs_a (.a(ea), .neg(esign & ea[XLEN-1]), .y(ma));
    pipe_mdu_abs #(.W(XLEN)) u_abs_b (.a(eb), .neg(esign & eb[XLEN-1]), .y(mb));
    pipe_mdu_abs #(.W(2*XLEN)) u_fix_p (.a(acc), .neg(rsign), .y(prod));

    // one shift-add step: add multiplicand into the upper half when the current multiplier bit is set, then shift right
    assign madd = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    assign mul_next = acc[0] ? {madd, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

`ifdef MDU_DIV_EN
    logic [2*XLEN:0]   sh;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rmd;
    logic              ge;
    logic              dsign;
    logic              dz;
    logic              opdiv;

    // restoring step: remainder in the upper half, dividend shifting out of / quotient shifting into the lower half
    assign sh = {acc, 1'b0};
    assign ge = sh[2*XLEN:XLEN] >= {1'b0, mcand};
    assign diff = sh[2*XLEN-1:XLEN] - mcand;
    assign div_next = ge ? {diff, sh[XLEN-1:1], 1'b1} : sh[2*XLEN-1:0];

    pipe_mdu_abs #(.W(XLEN)) u_fix_q (.a(acc[XLEN-1:0]), .neg(rsign), .y(quot));
    pipe_mdu_abs #(.W(XLEN)) u_fix_r (.a(acc[2*XLEN-1:XLEN]), .neg(dsign), .y(rmd));

    assign start = (state == IDLE) & emult;
    assign run_st = ediv ? DIV : MUL;
    assign res = opdiv ? {rmd, dz ? XLEN'(DIV0_QUOT) : quot} : prod;

    // divide-only side information latched at start for the fix-up cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dsign <= 1'b0;
            dz    <= 1'b0;
            opdiv <= 1'b0;
        end else if (start) begin
            dsign <= esign & ea[XLEN-1];
            dz    <= mb == '0;
            opdiv <= ediv;
        end
    end
`else
    assign start = (state == IDLE) & emult & ~ediv;
    assign run_st = MUL;
    assign res = prod;
`endif

    // sequencer: capture magnitudes, iterate 32 times, sign-fix into HI/LO
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
            mcand <= '0;
            rsign <= 1'b0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= run_st;
                    count <= '0;
                    acc   <= {{XLEN{1'b0}}, ma};
                    mcand <= mb;
                    rsign <= esign & (ea[XLEN-1] ^ eb[XLEN-1]);
                    busy  <= 1'b1;
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + CW'(1);
                    if (last_iter(count)) state <= FIX;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    acc   <= div_next;
                    count <= count + CW'(1);
                    if (last_iter(count)) state <= FIX;
                end
`endif
                FIX: begin
                    {hi, lo} <= res;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mdu_busy  = busy;
    assign mdu_stall = busy & (emult | emfhi | emflo);
    assign mdu_out   = emfhi ? hi : emflo ? lo : '0;

endmodule

// File: tb/tb_pipe_mdu.sv
// tb_pipe_mdu: directed bench for pipe_mdu with an arithmetic reference model checked every cycle
module tb_pipe_mdu;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk, clrn;
    logic [31:0] ea, eb;
    logic        emult, esign, ediv, emfhi, emflo;
    logic [31:0] mdu_out, hi, lo;
    logic        mdu_busy, mdu_stall;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 0;

    pipe_mdu dut (
        .clk(clk), .clrn(clrn), .ea(ea), .eb(eb), .emult(emult), .esign(esign),
        .ediv(ediv), .emfhi(emfhi), .emflo(emflo), .mdu_out(mdu_out),
        .mdu_busy(mdu_busy), .mdu_stall(mdu_stall), .hi(hi), .lo(lo)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // reference model: cycles left until HI/LO update, and the result computed arithmetically at start
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_left = 0;
            m_hi = 0;
            m_lo = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (emult && (DIV_EN || !ediv)) begin
            if (ediv) begin
                if (eb == 0) begin
                    p_lo = 32'hFFFF_FFFF;
                    p_hi = ea;
                end else if (esign) begin
                    p_lo = 32'($signed(ea) / $signed(eb));
                    p_hi = 32'($signed(ea) % $signed(eb));
                end else begin
                    p_lo = ea / eb;
                    p_hi = ea % eb;
                end
            end else begin
                logic [63:0] a64, b64, p;
                a64 = esign ? {{32{ea[31]}}, ea} : {32'b0, ea};
                b64 = esign ? {{32{eb[31]}}, eb} : {32'b0, eb};
                p = a64 * b64;
                {p_hi, p_lo} = p;
            end
            m_left = 33;
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_busy", 32'(mdu_busy), 32'(m_left > 0));
            chk("cyc_stall", 32'(mdu_stall), 32'((m_left > 0) && (emult || emfhi || emflo)));
            chk("cyc_out", mdu_out, emfhi ? m_hi : emflo ? m_lo : 32'h0);
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic m, input logic s,
                         input logic d, input logic fh, input logic fl);
        ea = a; eb = b; emult = m; esign = s; ediv = d; emfhi = fh; emflo = fl;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mdu_busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(mdu_busy), 32'h0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic d);
        drive(a, b, 1, s, d, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        wait_idle();
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        s;
        logic [31:0] h, l;
    } vec_t;

    vec_t vecs[5] = '{
        '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000},
        '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 32'h0000_0000, 32'h0000_000F},
        '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001},
        '{32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000},
        '{32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000}
    };

    initial begin
        int n;
        clrn = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        run_cmp = 1;
        repeat (3) tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(mdu_busy), 32'h0);
        chk("rst_stall", 32'(mdu_stall), 32'h0);
        clrn = 1;
        tick();

        // signed -2 x 3 with mfhi following one cycle behind
        drive(32'hFFFF_FFFE, 32'd3, 1, 1, 0, 0, 0);
        tick();
        drive(32'hFFFF_FFFE, 32'd3, 0, 1, 0, 1, 0);
        n = 0;
        while (mdu_stall && n < 100) begin
            n++;
            tick();
        end
        chk("t1_stall_cycles", 32'(n), 32'd33);
        chk("t1_mfhi", mdu_out, 32'hFFFF_FFFF);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFFA);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // unsigned max x max
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("t2_hi", hi, 32'hFFFF_FFFE);
        chk("t2_lo", lo, 32'h0000_0001);

        // back-to-back: second mult held through the first
        drive(32'd3, 32'd4, 1, 0, 0, 0, 0);
        tick();
        drive(32'd6, 32'd7, 1, 0, 0, 0, 0);
        n = 0;
        while (mdu_stall && n < 100) begin
            n++;
            tick();
        end
        chk("t3_stall_cycles", 32'(n), 32'd33);
        chk("t3_first_lo", lo, 32'd12);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t3_second_start", 32'(mdu_busy), 32'h1);
        wait_idle();
        chk("t3_hi", hi, 32'h0);
        chk("t3_lo", lo, 32'd42);

        // assorted signed/unsigned products
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0);
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].h);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].l);
        end

        // reset asserted at iteration 10 of 5 x 7
        drive(32'd5, 32'd7, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        clrn = 0;
        #1;
        chk("t4_hi", hi, 32'h0);
        chk("t4_lo", lo, 32'h0);
        chk("t4_busy", 32'(mdu_busy), 32'h0);
        tick();
        clrn = 1;
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("t4_mflo", mdu_out, 32'h0);
        chk("t4_mflo_stall", 32'(mdu_stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (40) tick();
        chk("t4_late_lo", lo, 32'h0);

        // divide requests
        run_op(32'd5, 32'd7, 0, 0);
`ifdef MDU_DIV_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1, 1);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(32'd9, 32'd0, 1, 1);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'd9);
        run_op(32'd100, 32'd7, 0, 1);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
`else
        drive(32'd5, 32'd7, 1, 0, 1, 0, 0);
        tick();
        chk("nodiv_busy", 32'(mdu_busy), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (40) tick();
        chk("nodiv_hi", hi, 32'h0);
        chk("nodiv_lo", lo, 32'd35);
`endif

        // illegal mult+mfhi: start taken, read shows pre-start HI
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        drive(32'd2, 32'd3, 1, 0, 0, 1, 0);
        #1;
        chk("t6_pre_hi", mdu_out, 32'hFFFF_FFFE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("t6_started", 32'(mdu_busy), 32'h1);
        wait_idle();
        chk("t6_hi", hi, 32'h0);
        chk("t6_lo", lo, 32'd6);

        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
